// File: rtl/prog_seq_ctr_pkg.sv
// Shared types and helpers for the program-counter / fetch sequencer.
// The FSM states, the ProgSel width rule and the entry-address mapping live here.
package prog_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_e;

    // A single resident program still needs a 1-bit select port.
    function automatic int psel_width(input int num_progs);
        return (num_progs > 1) ? $clog2(num_progs) : 1;
    endfunction

    localparam int DEF_NUM_PROGS = 4;
    localparam int PSEL_W        = psel_width(DEF_NUM_PROGS);

    function automatic logic [31:0] entry_addr(input int unsigned idx, input int unsigned stride);
        return 32'(idx * stride);
    endfunction

endpackage

// File: rtl/prog_seq_ctr_ret_stack.sv
// Return-address LIFO. Push when full and pop when empty are ignored;
// the top entry is presented combinationally on dout.
module ret_stack #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int SPW = $clog2(DEPTH + 1);

    logic [SPW-1:0] sp;
    logic [W-1:0]   mem [DEPTH];

    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            sp <= '0;
        else if (clr)
            sp <= '0;
        else if (push && !full)
            sp <= sp + 1'b1;
        else if (pop && !empty)
            sp <= sp - 1'b1;
    end

    // Storage carries no reset: only entries below sp are ever read.
    always_ff @(posedge Clk) begin
        if (push && !full && !clr) begin
            for (int i = 0; i < DEPTH; i++)
                if (sp == SPW'(i))
                    mem[i] <= din;
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++)
            if (sp == SPW'(i + 1))
                dout = mem[i];
    end

endmodule

// File: rtl/prog_seq_ctr.sv
// Program counter / instruction-fetch sequencer with program select,
// jumps, relative branches and a hardware call/return stack.
module prog_seq_ctr
    import prog_seq_pkg::*;
#(
    parameter int L           = 10,
    parameter int NUM_PROGS   = 4,
    parameter int PROG_STRIDE = 256,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic                             Start,
    input  logic [psel_width(NUM_PROGS)-1:0] ProgSel,
    input  logic                             Stall,
    input  logic                             Jump,
    input  logic                             Branch,
    input  logic                             IsEqual,
    input  logic                             Call,
    input  logic                             Ret,
    input  logic                             Halt,
    input  logic [L-1:0]                     Target,
    output logic [L-1:0]                     ProgCtr,
    output logic                             Running,
    output logic                             Done,
    output logic                             StackErr
);

    if (PROG_STRIDE * (NUM_PROGS - 1) >= 2 ** L) begin : g_bad_cfg
        $error("prog_seq_ctr: last program entry does not fit in L address bits");
    end
    if (STACK_DEPTH < 1) begin : g_bad_depth
        $error("prog_seq_ctr: STACK_DEPTH must be at least 1");
    end

    state_e       state_q, state_d;
    logic [L-1:0] pc_d, pc_inc, entry;
    logic         err_d;
    logic         push, pop, clr;
    logic [L-1:0] stk_top;
    logic         stk_full, stk_empty;

    assign pc_inc = ProgCtr + 1'b1;
    assign entry  = L'(entry_addr(32'(ProgSel), 32'(PROG_STRIDE)));

    ret_stack #(
        .W     (L),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr     (clr),
        .push    (push),
        .pop     (pop),
        .din     (pc_inc),
        .dout    (stk_top),
        .full    (stk_full),
        .empty   (stk_empty)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            ProgCtr  <= '0;
            StackErr <= 1'b0;
            Running  <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ProgCtr  <= pc_d;
            StackErr <= err_d;
            Running  <= (state_d == RUN);
            Done     <= (state_d == HALTED);
        end
    end

    // Start overrides everything in every state; each sampled Start reloads the entry.
    always_comb begin
        state_d = state_q;
        pc_d    = ProgCtr;
        err_d   = StackErr;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        if (Start) begin
            state_d = LOAD;
            pc_d    = entry;
            err_d   = 1'b0;
            clr     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                end
                LOAD: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (Halt) begin
                        state_d = HALTED;
                    end else if (Stall) begin
                    end else if (Ret) begin
                        if (stk_empty) begin
                            err_d = 1'b1;
                            pc_d  = pc_inc;
                        end else begin
                            pop  = 1'b1;
                            pc_d = stk_top;
                        end
                    end else if (Call) begin
                        pc_d = Target;
                        if (stk_full)
                            err_d = 1'b1;
                        else
                            push = 1'b1;
                    end else if (Jump) begin
                        pc_d = Target;
                    end else if (Branch && IsEqual) begin
                        // Unsigned L-bit add is the two's-complement offset add mod 2**L.
                        pc_d = ProgCtr + Target;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                HALTED: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_seq_ctr.sv
// Randomised and directed bench for prog_seq_ctr against a queue-based reference model.
module tb_prog_seq_ctr;

    localparam int L     = 10;
    localparam int AMOD  = 1 << L;
    localparam int STR   = 256;
    localparam int DEPTH = 4;

    logic         Clk, Reset_n;
    logic         Start, Stall, Jump, Branch, IsEqual, Call, Ret, Halt;
    logic [1:0]   ProgSel;
    logic [L-1:0] Target;
    logic [L-1:0] ProgCtr;
    logic         Running, Done, StackErr;

    int n_chk, n_fail;

    // Reference model: mode 0=idle 1=load 2=run 3=halted
    int m_mode, m_pc;
    bit m_err;
    int m_stk[$];

    prog_seq_ctr #(.L(L), .NUM_PROGS(4), .PROG_STRIDE(STR), .STACK_DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .ProgSel(ProgSel), .Stall(Stall),
        .Jump(Jump), .Branch(Branch), .IsEqual(IsEqual), .Call(Call), .Ret(Ret),
        .Halt(Halt), .Target(Target), .ProgCtr(ProgCtr), .Running(Running),
        .Done(Done), .StackErr(StackErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_pc = 0; m_err = 0;
        m_stk.delete();
    endfunction

    function automatic void model_step();
        int off;
        if (Start) begin
            m_mode = 1; m_pc = (int'(ProgSel) * STR) % AMOD; m_err = 0;
            m_stk.delete();
        end else if (m_mode == 1) begin
            m_mode = 2;
        end else if (m_mode == 2) begin
            if (Halt) m_mode = 3;
            else if (Stall) ;
            else if (Ret) begin
                if (m_stk.size() == 0) begin m_err = 1; m_pc = (m_pc + 1) % AMOD; end
                else m_pc = m_stk.pop_back();
            end else if (Call) begin
                if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % AMOD);
                else m_err = 1;
                m_pc = int'(Target);
            end else if (Jump) m_pc = int'(Target);
            else if (Branch && IsEqual) begin
                off = (int'(Target) >= AMOD / 2) ? int'(Target) - AMOD : int'(Target);
                m_pc = (m_pc + off + AMOD) % AMOD;
            end else m_pc = (m_pc + 1) % AMOD;
        end
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, ".pc"},   int'(ProgCtr),  m_pc);
        chk({tag, ".run"},  int'(Running),  int'(m_mode == 2));
        chk({tag, ".done"}, int'(Done),     int'(m_mode == 3));
        chk({tag, ".err"},  int'(StackErr), int'(m_err));
    endtask

    task automatic ctl_clear();
        Start = 0; Stall = 0; Jump = 0; Branch = 0; IsEqual = 0;
        Call = 0; Ret = 0; Halt = 0; Target = '0;
    endtask

    // Inputs are already set; advance one edge and compare one time unit later.
    task automatic step(input string tag);
        model_step();
        @(posedge Clk);
        #1;
        check_outs(tag);
    endtask

    task automatic jump_to(input int a);
        ctl_clear(); Jump = 1; Target = L'(a); step("jmp");
        ctl_clear();
    endtask

    task automatic async_reset(input string tag);
        #2 Reset_n = 0;
        #1;
        model_reset();
        check_outs(tag);
        #2 Reset_n = 1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        ctl_clear(); ProgSel = 0;
        Reset_n = 0;
        model_reset();
        #12;
        check_outs("rst");
        Reset_n = 1;
        step("idle"); step("idle");

        // Program 2 selected for three cycles, then run
        Start = 1; ProgSel = 2;
        step("load"); step("load"); step("load");
        chk("entry2", int'(ProgCtr), 512);
        Start = 0;
        step("l2r"); step("run"); step("run");
        chk("run514", int'(ProgCtr), 514);

        // Branching
        jump_to(520);
        Branch = 1; IsEqual = 1; Target = 10'h3FD; step("br_tk");
        chk("br517", int'(ProgCtr), 517);
        jump_to(520);
        Branch = 1; IsEqual = 0; Target = 10'h3FD; step("br_nt");
        chk("br521", int'(ProgCtr), 521);
        jump_to(10'h050);
        chk("jmp50", int'(ProgCtr), 10'h050);
        ctl_clear(); Stall = 1; step("stall"); step("stall");
        chk("stall", int'(ProgCtr), 10'h050);

        // Call / return
        jump_to(600);
        Call = 1; Target = 10'd700; step("call");
        ctl_clear(); step("adv"); step("adv");
        Ret = 1; step("ret");
        chk("ret601", int'(ProgCtr), 601);
        for (int i = 1; i <= 5; i++) begin
            ctl_clear(); Call = 1; Target = L'(i * 100); step("ncall");
        end
        chk("ovf_err", int'(StackErr), 1);
        chk("ovf_pc", int'(ProgCtr), 500);
        for (int i = 0; i < 5; i++) begin
            ctl_clear(); Ret = 1; step("nret");
        end
        ctl_clear();

        // Wrap and priority
        jump_to(1023); step("wrap");
        chk("wrap0", int'(ProgCtr), 0);
        jump_to(1020);
        Branch = 1; IsEqual = 1; Target = 10'd8; step("brwrap");
        chk("brwrap4", int'(ProgCtr), 4);
        ctl_clear(); Call = 1; Target = 10'd50; step("pcall");
        Call = 1; Ret = 1; Jump = 1; Target = 10'd300; step("prio");
        chk("prio5", int'(ProgCtr), 5);

        // Halt and restart
        jump_to(530);
        Halt = 1; step("halt");
        ctl_clear(); Jump = 1; Target = 10'd77; step("hjmp");
        ctl_clear(); Branch = 1; IsEqual = 1; Target = 10'd5; step("hbr");
        chk("hold530", int'(ProgCtr), 530);
        ctl_clear(); Ret = 1; step("herr");
        ctl_clear(); Start = 1; ProgSel = 1; step("restart");
        chk("entry1", int'(ProgCtr), 256);
        Start = 0; step("rerun");

        // Async reset mid-RUN
        jump_to(10'h123);
        async_reset("arst");
        step("arst_idle");

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            ctl_clear();
            Start   = ($urandom_range(0, 39) == 0);
            ProgSel = 2'($urandom_range(0, 3));
            Halt    = ($urandom_range(0, 29) == 0);
            Stall   = ($urandom_range(0, 5) == 0);
            Jump    = ($urandom_range(0, 4) == 0);
            Branch  = ($urandom_range(0, 3) == 0);
            IsEqual = ($urandom_range(0, 1) == 0);
            Call    = ($urandom_range(0, 4) == 0);
            Ret     = ($urandom_range(0, 4) == 0);
            Target  = L'($urandom_range(0, AMOD - 1));
            step("rnd");
            if ($urandom_range(0, 499) == 0) async_reset("rnd_arst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
